// File: rtl/apu_package.sv
// Shared APU type/config constants and the per-operation payload layout.
package apu_package;

    localparam int unsigned C_APUTYPES     = 5;
    localparam int unsigned NB_APUTYPES    = C_APUTYPES;
    localparam int unsigned WAPUTYPE       = 3;
    localparam int unsigned NARGS_CPU      = 3;
    localparam int unsigned WOP_CPU        = 6;
    localparam int unsigned NDSFLAGS_CPU   = 15;
    localparam int unsigned NUSFLAGS_CPU   = 5;
    localparam int unsigned DATA_WIDTH_CPU = 32;

    typedef struct packed {
        logic [NARGS_CPU-1:0][DATA_WIDTH_CPU-1:0] operands;
        logic [WOP_CPU-1:0]                       op;
        logic [NDSFLAGS_CPU-1:0]                  flags;
    } apu_payload_t;

    // Core-ID width; a single-core cluster still needs one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apu_dispatch_id_fifo.sv
// Synchronous FIFO of issuing-core IDs for one shared APU unit.
module apu_dispatch_id_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNTW-1:0]  count_o
);

    localparam int unsigned PTRW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTRW-1:0]             wr_q, rd_q;
    logic [CNTW-1:0]             cnt_q;
    logic                        do_push, do_pop;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTRW'(1);
    endfunction

    assign full_o  = (cnt_q == CNTW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin : ptr_p
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CNTW'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - CNTW'(1);
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk_i) begin : mem_p
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/apu_dispatch_arbiter.sv
// Round-robin dispatch of core APU requests onto shared units, with result return.
// Optional perf counters: define APU_DISPATCH_PERF_EN.
module apu_dispatch_arbiter #(
    parameter int unsigned NB_CORES      = 8,
    parameter int unsigned NB_APUTYPES   = apu_package::NB_APUTYPES,
    parameter int unsigned WAPUTYPE      = apu_package::WAPUTYPE,
    parameter int unsigned NARGS         = apu_package::NARGS_CPU,
    parameter int unsigned DATA_WIDTH    = apu_package::DATA_WIDTH_CPU,
    parameter int unsigned WOP           = apu_package::WOP_CPU,
    parameter int unsigned NDSFLAGS      = apu_package::NDSFLAGS_CPU,
    parameter int unsigned NUSFLAGS      = apu_package::NUSFLAGS_CPU,
    parameter int unsigned ID_FIFO_DEPTH = 4
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NB_CORES-1:0]                           core_req_i,
    output logic [NB_CORES-1:0]                           core_gnt_o,
    input  logic [NB_CORES-1:0][WAPUTYPE-1:0]             core_type_i,
    input  logic [NB_CORES-1:0][NARGS-1:0][DATA_WIDTH-1:0] core_operands_i,
    input  logic [NB_CORES-1:0][WOP-1:0]                  core_op_i,
    input  logic [NB_CORES-1:0][NDSFLAGS-1:0]             core_flags_i,
    output logic [NB_CORES-1:0]                           core_rvalid_o,
    output logic [NB_CORES-1:0][DATA_WIDTH-1:0]           core_result_o,
    output logic [NB_CORES-1:0][NUSFLAGS-1:0]             core_rflags_o,
    output logic [NB_APUTYPES-1:0]                        unit_req_o,
    input  logic [NB_APUTYPES-1:0]                        unit_gnt_i,
    output logic [NB_APUTYPES-1:0][NARGS-1:0][DATA_WIDTH-1:0] unit_operands_o,
    output logic [NB_APUTYPES-1:0][WOP-1:0]               unit_op_o,
    output logic [NB_APUTYPES-1:0][NDSFLAGS-1:0]          unit_flags_o,
    input  logic [NB_APUTYPES-1:0]                        unit_rvalid_i,
    input  logic [NB_APUTYPES-1:0][DATA_WIDTH-1:0]        unit_result_i,
    input  logic [NB_APUTYPES-1:0][NUSFLAGS-1:0]          unit_rflags_i,
    input  logic                                          perf_clear_i,
    output logic [NB_APUTYPES-1:0][31:0]                  perf_issue_o,
    output logic [NB_APUTYPES-1:0][31:0]                  perf_contention_o
);

    localparam int unsigned IDW  = apu_package::id_width(NB_CORES);
    localparam int unsigned CNTW = $clog2(ID_FIFO_DEPTH + 1);

    logic [NB_CORES-1:0]                     busy_q;
    logic [NB_APUTYPES-1:0][IDW-1:0]         rr_q, sel, head;
    logic [NB_APUTYPES-1:0][NB_CORES-1:0]    cand;
    logic [NB_APUTYPES-1:0]                  any_cand, fifo_full, fifo_empty, issue, pop;
    logic [NB_APUTYPES-1:0][CNTW-1:0]        fifo_cnt;
    logic [NB_CORES-1:0]                     illegal;
    logic [NB_CORES-1:0]                     rvalid_q;
    logic [NB_CORES-1:0][DATA_WIDTH-1:0]     result_q;
    logic [NB_CORES-1:0][NUSFLAGS-1:0]       rflags_q;

    // Idle, requesting cores sorted by target unit; out-of-range types are illegal.
    always_comb begin : cand_p
        cand    = '0;
        illegal = '0;
        for (int c = 0; c < int'(NB_CORES); c++) begin
            if (rst_ni && core_req_i[c] && !busy_q[c]) begin
                if (32'(core_type_i[c]) >= NB_APUTYPES) illegal[c] = 1'b1;
                for (int u = 0; u < int'(NB_APUTYPES); u++)
                    if (32'(core_type_i[c]) == 32'(u)) cand[u][c] = 1'b1;
            end
        end
    end

    // Scan from the highest offset down so the candidate nearest rr_q wins.
    always_comb begin : sel_p
        logic [IDW-1:0] idx;
        idx      = '0;
        sel      = '0;
        any_cand = '0;
        for (int u = 0; u < int'(NB_APUTYPES); u++) begin
            for (int k = int'(NB_CORES) - 1; k >= 0; k--) begin
                idx = IDW'((32'(rr_q[u]) + 32'(k)) % NB_CORES);
                if (cand[u][idx]) begin
                    sel[u]      = idx;
                    any_cand[u] = 1'b1;
                end
            end
        end
    end

    assign unit_req_o = any_cand & ~fifo_full;
    assign issue      = unit_req_o & unit_gnt_i;
    assign pop        = unit_rvalid_i & ~fifo_empty;

    always_comb begin : payload_p
        unit_operands_o = '0;
        unit_op_o       = '0;
        unit_flags_o    = '0;
        for (int u = 0; u < int'(NB_APUTYPES); u++) begin
            if (any_cand[u]) begin
                unit_operands_o[u] = core_operands_i[sel[u]];
                unit_op_o[u]       = core_op_i[sel[u]];
                unit_flags_o[u]    = core_flags_i[sel[u]];
            end
        end
    end

    always_comb begin : gnt_p
        core_gnt_o = illegal;
        for (int u = 0; u < int'(NB_APUTYPES); u++)
            if (issue[u]) core_gnt_o[sel[u]] = 1'b1;
    end

    // A core has at most one op in flight, so illegal replies and unit returns never collide.
    always_ff @(posedge clk_i) begin : state_p
        if (!rst_ni) begin
            busy_q   <= '0;
            rr_q     <= '0;
            rvalid_q <= '0;
            result_q <= '0;
            rflags_q <= '0;
        end else begin
            rvalid_q <= illegal;
            for (int c = 0; c < int'(NB_CORES); c++) begin
                if (illegal[c]) begin
                    result_q[c] <= '0;
                    rflags_q[c] <= '1;
                end
            end
            for (int u = 0; u < int'(NB_APUTYPES); u++) begin
                if (pop[u]) begin
                    busy_q[head[u]]   <= 1'b0;
                    rvalid_q[head[u]] <= 1'b1;
                    result_q[head[u]] <= unit_result_i[u];
                    rflags_q[head[u]] <= unit_rflags_i[u];
                end
                if (issue[u]) begin
                    busy_q[sel[u]] <= 1'b1;
                    rr_q[u]        <= IDW'((32'(sel[u]) + 32'd1) % NB_CORES);
                end
            end
        end
    end

    assign core_rvalid_o = rvalid_q;
    assign core_result_o = result_q;
    assign core_rflags_o = rflags_q;

    for (genvar u = 0; u < int'(NB_APUTYPES); u++) begin : g_fifo
        apu_dispatch_id_fifo #(
            .WIDTH (IDW),
            .DEPTH (ID_FIFO_DEPTH),
            .CNTW  (CNTW)
        ) u_id_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (issue[u]),
            .data_i  (sel[u]),
            .pop_i   (pop[u]),
            .data_o  (head[u]),
            .full_o  (fifo_full[u]),
            .empty_o (fifo_empty[u]),
            .count_o (fifo_cnt[u])
        );
    end

    // A result with nothing in flight is dropped; flag it in simulation.
    always_ff @(posedge clk_i) begin : empty_pop_chk_p
        for (int u = 0; u < int'(NB_APUTYPES); u++)
            if (rst_ni && unit_rvalid_i[u])
                assert (fifo_cnt[u] != '0)
                else $warning("apu_dispatch_arbiter: result on unit %0d with no op in flight, dropped", u);
    end

`ifdef APU_DISPATCH_PERF_EN
    logic [NB_APUTYPES-1:0][31:0] issue_cnt_q, cont_cnt_q;
    logic [NB_APUTYPES-1:0]       contend;

    always_comb begin : contend_p
        contend = '0;
        for (int u = 0; u < int'(NB_APUTYPES); u++)
            contend[u] = ($countones(cand[u]) >= 2) || (any_cand[u] && !issue[u]);
    end

    // Saturating counters; clear takes priority over increment.
    always_ff @(posedge clk_i) begin : perf_p
        if (!rst_ni || perf_clear_i) begin
            issue_cnt_q <= '0;
            cont_cnt_q  <= '0;
        end else begin
            for (int u = 0; u < int'(NB_APUTYPES); u++) begin
                if (issue[u] && issue_cnt_q[u] != '1) issue_cnt_q[u] <= issue_cnt_q[u] + 32'd1;
                if (contend[u] && cont_cnt_q[u] != '1) cont_cnt_q[u] <= cont_cnt_q[u] + 32'd1;
            end
        end
    end

    assign perf_issue_o      = issue_cnt_q;
    assign perf_contention_o = cont_cnt_q;
`else
    logic unused_perf_clear;
    assign unused_perf_clear = perf_clear_i;
    assign perf_issue_o      = '0;
    assign perf_contention_o = '0;
`endif

endmodule

// File: tb/tb_apu_dispatch_arbiter.sv
// Scoreboard bench for apu_dispatch_arbiter: directed stimulus, monitor checks grants and results.
module tb_apu_dispatch_arbiter;

    localparam int NC = 8, NU = 5, WT = 3, NA = 3, DW = 32, WOP = 6, NDS = 15, NUS = 5, DEPTH = 4;
`ifdef APU_DISPATCH_PERF_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NC-1:0]                  core_req = '0, core_gnt, core_rvalid;
    logic [NC-1:0][WT-1:0]          core_type = '0;
    logic [NC-1:0][NA-1:0][DW-1:0]  core_ops = '0;
    logic [NC-1:0][WOP-1:0]         core_op = '0;
    logic [NC-1:0][NDS-1:0]         core_flags = '0;
    logic [NC-1:0][DW-1:0]          core_result;
    logic [NC-1:0][NUS-1:0]         core_rflags;
    logic [NU-1:0]                  unit_req, unit_gnt = '0, unit_rvalid = '0;
    logic [NU-1:0][NA-1:0][DW-1:0]  unit_ops;
    logic [NU-1:0][WOP-1:0]         unit_op;
    logic [NU-1:0][NDS-1:0]         unit_flags;
    logic [NU-1:0][DW-1:0]          unit_result = '0;
    logic [NU-1:0][NUS-1:0]         unit_rflags = '0;
    logic                           perf_clear = 1'b0;
    logic [NU-1:0][31:0]            perf_issue, perf_cont;

    typedef struct { int core; int cyc; } gexp_t;
    typedef struct { int core; logic [DW-1:0] res; logic [NUS-1:0] fl; int cyc; } rexp_t;
    gexp_t gnt_q[$];
    rexp_t res_q[$];
    gexp_t ge;
    rexp_t re;
    int found;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int t0;

    apu_dispatch_arbiter #(
        .NB_CORES(NC), .NB_APUTYPES(NU), .WAPUTYPE(WT), .NARGS(NA), .DATA_WIDTH(DW),
        .WOP(WOP), .NDSFLAGS(NDS), .NUSFLAGS(NUS), .ID_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_i(core_req), .core_gnt_o(core_gnt), .core_type_i(core_type),
        .core_operands_i(core_ops), .core_op_i(core_op), .core_flags_i(core_flags),
        .core_rvalid_o(core_rvalid), .core_result_o(core_result), .core_rflags_o(core_rflags),
        .unit_req_o(unit_req), .unit_gnt_i(unit_gnt), .unit_operands_o(unit_ops),
        .unit_op_o(unit_op), .unit_flags_o(unit_flags), .unit_rvalid_i(unit_rvalid),
        .unit_result_i(unit_result), .unit_rflags_i(unit_rflags),
        .perf_clear_i(perf_clear), .perf_issue_o(perf_issue), .perf_contention_o(perf_cont)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
        unit_rvalid = '0;
    endtask

    task automatic set_req(input int c, input int t);
        core_req[c]  = 1'b1;
        core_type[c] = WT'(t);
        for (int a = 0; a < NA; a++) core_ops[c][a] = 32'h1000_0000 + 32'(c * 16 + a);
        core_op[c]    = WOP'(c + 1);
        core_flags[c] = NDS'(32'h100 + 32'(c));
    endtask

    task automatic clr_req(input int c);
        core_req[c] = 1'b0;
    endtask

    task automatic exp_gnt(input int c, input int at);
        gnt_q.push_back('{c, at});
    endtask

    task automatic exp_res(input int c, input logic [DW-1:0] r, input logic [NUS-1:0] f, input int at);
        res_q.push_back('{c, r, f, at});
    endtask

    // Unit u answers now; the result reaches core c one cycle later.
    task automatic unit_ret(input int u, input logic [DW-1:0] r, input logic [NUS-1:0] f, input int c);
        unit_rvalid[u] = 1'b1;
        unit_result[u] = r;
        unit_rflags[u] = f;
        exp_res(c, r, f, cyc + 1);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every grant and every result pulse must match the next expectation.
    always @(negedge clk) begin
        for (int c = 0; c < NC; c++) begin
            if (core_gnt[c]) begin
                tests++;
                if (gnt_q.size() == 0) begin
                    fails++;
                    $display("FAIL gnt_unexpected: core %0d granted at cycle %0d, expected no grant", c, cyc);
                end else begin
                    ge = gnt_q.pop_front();
                    if (ge.core != c || ge.cyc != cyc) begin
                        fails++;
                        $display("FAIL gnt_order: got core %0d at cycle %0d, expected core %0d at cycle %0d",
                                 c, cyc, ge.core, ge.cyc);
                    end
                end
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (core_rvalid[c]) begin
                tests++;
                found = -1;
                for (int i = 0; i < res_q.size(); i++)
                    if (found < 0 && res_q[i].core == c) found = i;
                if (found < 0) begin
                    fails++;
                    $display("FAIL rvalid_unexpected: core %0d rvalid at cycle %0d, expected none", c, cyc);
                end else begin
                    re = res_q[found];
                    res_q.delete(found);
                    if (re.res !== core_result[c] || re.fl !== core_rflags[c] || re.cyc != cyc) begin
                        fails++;
                        $display("FAIL result_core%0d: got %0h/%0h at cycle %0d, expected %0h/%0h at cycle %0d",
                                 c, core_result[c], core_rflags[c], cyc, re.res, re.fl, re.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected under 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick(); tick();
        check("reset_outputs_zero", 64'(|{core_gnt, core_rvalid, core_result, core_rflags, unit_req,
              unit_ops, unit_op, unit_flags, perf_issue, perf_cont}), 64'd0);
        rst_n = 1'b1;
        unit_gnt = '1;
        tick();

        // Single issue, busy block, re-grant in the rvalid cycle
        t0 = cyc;
        set_req(2, 1);
        exp_gnt(2, t0);
        #1;
        check("single_unit_req", 64'(unit_req[1]), 64'd1);
        check("single_payload_op", 64'(unit_op[1]), 64'd3);
        check("single_payload_opnd0", 64'(unit_ops[1][0]), 64'h1000_0020);
        check("single_payload_flags", 64'(unit_flags[1]), 64'h102);
        tick(); clr_req(2);
        tick(); set_req(2, 1);
        #1;
        check("busy_blocks_req", 64'(unit_req[1]), 64'd0);
        tick(); tick();
        unit_ret(1, 32'h3F80_0000, 5'h01, 2);
        tick(); exp_gnt(2, cyc);
        tick(); clr_req(2); unit_ret(1, 32'h4000_0000, 5'h00, 2);
        tick();

        // Round-robin among cores 0, 3, 5 on unit 0
        t0 = cyc;
        set_req(0, 0); set_req(3, 0); set_req(5, 0);
        exp_gnt(0, t0); exp_gnt(3, t0 + 1); exp_gnt(5, t0 + 2); exp_gnt(0, t0 + 4);
        tick(); clr_req(0);
        tick(); clr_req(3);
        tick(); clr_req(5); unit_ret(0, 32'hA0, 5'h02, 0);
        tick(); set_req(0, 0);
        tick(); clr_req(0); unit_ret(0, 32'hA3, 5'h03, 3);
        tick(); unit_ret(0, 32'hA5, 5'h04, 5);
        tick(); unit_ret(0, 32'hB0, 5'h05, 0);
        tick();

        // FIFO full stall on unit 2, released by the first pop
        t0 = cyc;
        for (int c = 0; c < 5; c++) set_req(c, 2);
        exp_gnt(0, t0); exp_gnt(1, t0 + 1); exp_gnt(2, t0 + 2); exp_gnt(3, t0 + 3);
        tick(); clr_req(0);
        tick(); clr_req(1);
        tick(); clr_req(2);
        tick(); clr_req(3);
        #1;
        check("fifo_full_stall", 64'(unit_req[2]), 64'd0);
        unit_ret(2, 32'hC0, 5'h00, 0);
        tick();
        check("fifo_release", 64'(unit_req[2]), 64'd1);
        exp_gnt(4, cyc);
        unit_ret(2, 32'hC1, 5'h01, 1);
        tick(); clr_req(4); unit_ret(2, 32'hC2, 5'h02, 2);
        tick(); unit_ret(2, 32'hC3, 5'h03, 3);
        tick(); unit_ret(2, 32'hC4, 5'h04, 4);
        tick();

        // Illegal types (5 and 7)
        t0 = cyc;
        set_req(6, 5); set_req(7, 7);
        exp_gnt(6, t0); exp_gnt(7, t0);
        exp_res(6, '0, '1, t0 + 1); exp_res(7, '0, '1, t0 + 1);
        #1;
        check("illegal_no_unit_req", 64'(unit_req), 64'd0);
        tick(); clr_req(6); clr_req(7);
        tick();

        // Unit back-pressure on unit 3
        unit_gnt[3] = 1'b0;
        set_req(1, 3);
        #1;
        check("bp_unit_req", 64'(unit_req[3]), 64'd1);
        tick();
        check("bp_hold_flags", 64'(unit_flags[3]), 64'h101);
        tick(); unit_gnt[3] = 1'b1; exp_gnt(1, cyc);
        tick(); clr_req(1); unit_ret(3, 32'hD1, 5'h1E, 1);
        #1;
        check("idle_payload_zero", 64'(unit_ops[3][0]), 64'd0);
        tick();

        // Reset with three ops in flight on unit 4
        t0 = cyc;
        set_req(0, 4); set_req(1, 4); set_req(2, 4);
        exp_gnt(0, t0); exp_gnt(1, t0 + 1); exp_gnt(2, t0 + 2);
        tick(); clr_req(0);
        tick(); clr_req(1);
        tick(); clr_req(2); rst_n = 1'b0;
        tick(); tick();
        check("midop_reset_zero", 64'(|{core_gnt, core_rvalid, core_result, core_rflags, unit_req,
              unit_ops, unit_op, unit_flags, perf_issue, perf_cont}), 64'd0);
        rst_n = 1'b1;
        tick(); unit_rvalid[4] = 1'b1; unit_result[4] = 32'hDEAD;
        tick();
        check("stale_result_dropped", 64'(core_rvalid), 64'd0);
        set_req(2, 4); set_req(5, 4);
        exp_gnt(2, cyc); exp_gnt(5, cyc + 1);
        tick(); clr_req(2);
        tick(); clr_req(5); unit_ret(4, 32'hE2, 5'h02, 2);
        tick(); unit_ret(4, 32'hE5, 5'h05, 5);
        tick();

        // Performance counters on unit 0
        perf_clear = 1'b1;
        tick(); perf_clear = 1'b0;
        check("perf_cleared", 64'(perf_cont[0]), 64'd0);
        unit_gnt[0] = 1'b0;
        set_req(1, 0); set_req(2, 0);
        repeat (10) tick();
        check("perf_contention_10", 64'(perf_cont[0]), 64'(PERF_ON * 10));
        unit_gnt[0] = 1'b1;
        exp_gnt(1, cyc);
        tick(); clr_req(1); exp_gnt(2, cyc);
        tick(); clr_req(2);
        check("perf_contention_11", 64'(perf_cont[0]), 64'(PERF_ON * 11));
        check("perf_issue_2", 64'(perf_issue[0]), 64'(PERF_ON * 2));
        unit_ret(0, 32'hF1, 5'h01, 1);
        tick(); unit_ret(0, 32'hF2, 5'h02, 2);
        tick(); perf_clear = 1'b1;
        tick(); perf_clear = 1'b0;
        check("perf_clear_cont", 64'(perf_cont[0]), 64'd0);
        check("perf_clear_issue", 64'(perf_issue[0]), 64'd0);

        tick(); tick();
        check("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
        check("res_queue_drained", 64'(res_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
